// File: rtl/smart_producer_pkg.sv
// rtl/smart_producer_pkg.sv - shared types, constants and LFSR step for the smart producer
package smart_producer_pkg;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_WALK = 2'd2,
    MODE_ALT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  localparam logic [3:0]  HDR_TAG        = 4'hA;
  // x^32 + x^22 + x^2 + x + 1, feedback taps below the x^32 term
  localparam logic [31:0] LFSR_POLY      = 32'h0040_0007;
  localparam logic [31:0] LFSR_SEED_BASE = 32'h0000_0001;
  localparam logic [31:0] ALT_EVEN       = 32'hAAAA_AAAA;
  localparam logic [31:0] ALT_ODD        = 32'h5555_5555;

  // One left-shifting Galois step: the bit leaving the top folds back through the taps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/smart_producer_ch.sv
// rtl/smart_producer_ch.sv - one producer channel: framing FSM, sequence, counter, LFSR, pattern mux
module smart_producer_ch
  import smart_producer_pkg::*;
#(
  parameter int CH_ID = 0,
  parameter int DW    = 32,
  parameter int LW    = 10
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  input  logic [LW-1:0] pkt_len_i,
  input  logic          done_i,
  input  logic          fifo_epty_i,
  input  logic          fifo_full_i,
  input  logic          fifo_almst_full_i,
  output logic          fifo_wr_o,
  output logic [DW-1:0] dt_o,
  output logic          err_o,
  output logic          busy_o
);

  localparam int            SW       = DW - 8;
  localparam int            BW       = 5;
  localparam logic [3:0]    CH_TAG   = 4'(CH_ID);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [31:0]   SEED     = LFSR_SEED_BASE + 32'(CH_ID);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] seq_q, seq_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [DW-1:0] dt_q, dt_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic          stall;
  logic [DW-1:0] pattern;

  assign stall     = fifo_almst_full_i | fifo_full_i;
  assign fifo_wr_o = wr_q;
  assign dt_o      = dt_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != ST_IDLE);

  // Payload word for the current index in the mode latched at packet start.
  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_CNT:  pattern = cnt_q;
      MODE_LFSR: pattern = lfsr_q[DW-1:0];
      MODE_WALK: pattern = {{(DW-1){1'b0}}, 1'b1} << bit_q;
      MODE_ALT:  pattern = idx_q[0] ? ALT_ODD[DW-1:0] : ALT_EVEN[DW-1:0];
      default:   pattern = '0;
    endcase
  end

  // Next-state, write strobe and data; a stalled cycle changes nothing but the error flag.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    dt_d    = dt_q;
    wr_d    = 1'b0;
    err_d   = err_q | (wr_q & fifo_full_i);
    case (state_q)
      ST_IDLE: begin
        if (en_i && fifo_epty_i) begin
          state_d = ST_HDR;
          mode_d  = mode_e'(mode_i);
          len_d   = (pkt_len_i == '0) ? LEN_ONE : pkt_len_i;
          idx_d   = '0;
          bit_d   = '0;
        end
      end
      ST_HDR: begin
        if (!stall) begin
          wr_d    = 1'b1;
          dt_d    = {HDR_TAG, CH_TAG, seq_q};
          seq_d   = seq_q + SW'(1);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!stall) begin
          wr_d  = 1'b1;
          dt_d  = pattern;
          idx_d = idx_q + LEN_ONE;
          bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
          if (mode_q == MODE_CNT)  cnt_d  = cnt_q + DW'(1);
          if (mode_q == MODE_LFSR) lfsr_d = lfsr_next(lfsr_q);
          if (idx_q == len_q - LEN_ONE) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel registers; reset aborts any packet in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_CNT;
      len_q   <= LEN_ONE;
      idx_q   <= '0;
      bit_q   <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      dt_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      dt_q    <= dt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/smart_producer_mc.sv
// rtl/smart_producer_mc.sv - NCH independent framed-packet producers sharing one clock
module smart_producer_mc
  import smart_producer_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DW  = 32,
  parameter int LW  = 10
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NCH-1:0]    en_i,
  input  logic [1:0]        mode_i,
  input  logic [LW-1:0]     pkt_len_i,
  input  logic [NCH-1:0]    done_i,
  input  logic [NCH-1:0]    fifo_epty_i,
  input  logic [NCH-1:0]    fifo_full_i,
  input  logic [NCH-1:0]    fifo_almst_full_i,
  output logic [NCH-1:0]    fifo_wr_o,
  output logic [NCH*DW-1:0] dt_o,
  output logic [NCH-1:0]    err_o,
  output logic [NCH-1:0]    busy_o
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    smart_producer_ch #(
      .CH_ID(c),
      .DW   (DW),
      .LW   (LW)
    ) u_ch (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .en_i             (en_i[c]),
      .mode_i           (mode_i),
      .pkt_len_i        (pkt_len_i),
      .done_i           (done_i[c]),
      .fifo_epty_i      (fifo_epty_i[c]),
      .fifo_full_i      (fifo_full_i[c]),
      .fifo_almst_full_i(fifo_almst_full_i[c]),
      .fifo_wr_o        (fifo_wr_o[c]),
      .dt_o             (dt_o[c*DW +: DW]),
      .err_o            (err_o[c]),
      .busy_o           (busy_o[c])
    );
  end

endmodule

// File: tb/tb_smart_producer_mc.sv
// tb/tb_smart_producer_mc.sv - directed bench with a packet-level reference model
module tb_smart_producer_mc;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int LW  = 10;

  logic              clk;
  logic              rstn;
  logic [NCH-1:0]    en, done, epty, full, afull;
  logic [1:0]        mode;
  logic [LW-1:0]     len;
  logic [NCH-1:0]    wr, err, busy;
  logic [NCH*DW-1:0] dt;

  smart_producer_mc #(.NCH(NCH), .DW(DW), .LW(LW)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .en_i             (en),
    .mode_i           (mode),
    .pkt_len_i        (len),
    .done_i           (done),
    .fifo_epty_i      (epty),
    .fifo_full_i      (full),
    .fifo_almst_full_i(afull),
    .fifo_wr_o        (wr),
    .dt_o             (dt),
    .err_o            (err),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int launch_cyc = 0;
  int jc = 0;

  logic [31:0]    exp_q[NCH][$];
  logic [31:0]    wlog[NCH][$];
  int             wcyc[NCH][$];
  logic [23:0]    m_seq[NCH];
  logic [31:0]    m_cnt[NCH];
  logic [31:0]    m_lfsr[NCH];
  logic [NCH-1:0] stall_s;
  logic [31:0]    cw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s << 1;
    if (s[31]) r = r ^ ((32'h1 << 22) | (32'h1 << 2) | (32'h1 << 1) | 32'h1);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_seq[c]  = '0;
      m_cnt[c]  = '0;
      m_lfsr[c] = 32'h1 + 32'(c);
      exp_q[c].delete();
    end
  endtask

  // Expected write sequence for one packet: header then payload per the mode rules.
  task automatic push_pkt(input int c, input int md, input int ln);
    int n;
    n = (ln == 0) ? 1 : ln;
    exp_q[c].push_back({4'hA, 4'(c), m_seq[c]});
    m_seq[c] = m_seq[c] + 24'd1;
    for (int i = 0; i < n; i++) begin
      case (md)
        0: begin exp_q[c].push_back(m_cnt[c]); m_cnt[c] = m_cnt[c] + 32'd1; end
        1: begin exp_q[c].push_back(m_lfsr[c]); m_lfsr[c] = lfsr_step(m_lfsr[c]); end
        2: exp_q[c].push_back(32'h1 << (i % 32));
        default: exp_q[c].push_back((i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555);
      endcase
    end
  endtask

  function automatic bit drained(input logic [NCH-1:0] msk);
    for (int c = 0; c < NCH; c++)
      if (msk[c] && exp_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Every write is checked against the model and must not occur on a stalled edge.
  always begin
    @(posedge clk);
    stall_s = afull | full;
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (wr[c]) begin
        cw = dt[c*DW +: DW];
        wlog[c].push_back(cw);
        wcyc[c].push_back(cyc);
        if (stall_s[c]) fail($sformatf("ch%0d_stall", c), "got write want none");
        if (exp_q[c].size() == 0) fail($sformatf("ch%0d_extra", c), $sformatf("got write %08h want none", cw));
        else chk($sformatf("ch%0d_word", c), cw, exp_q[c].pop_front());
      end
    end
  end

  task automatic launch(input logic [NCH-1:0] msk, input int md, input int ln);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (msk[c]) begin
        push_pkt(c, md, ln);
        wlog[c].delete();
        wcyc[c].delete();
      end
    end
    en   = msk;
    mode = 2'(md);
    len  = LW'(ln);
    @(negedge clk);
    en = '0;
    launch_cyc = cyc;
  endtask

  task automatic wait_drain(input logic [NCH-1:0] msk);
    int t;
    t = 0;
    while (!drained(msk) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!drained(msk)) fail("drain_timeout", "got pending words want none");
  endtask

  task automatic finish_pkt(input logic [NCH-1:0] msk);
    wait_drain(msk);
    @(negedge clk);
    chk("busy_wait_done", 32'(busy & msk), 32'(msk));
    done = msk;
    @(negedge clk);
    done = '0;
    chk("busy_after_done", 32'(busy & msk), 32'h0);
  endtask

  initial begin
    int t;
    en = '0; done = '0; epty = '1; full = '0; afull = '0;
    mode = '0; len = '0; rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_wr", 32'(wr), 32'h0);
    chk("rst_dt0", dt[31:0], 32'h0);
    chk("rst_dt1", dt[63:32], 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rstn = 1'b1;

    // Mode 0, len 4 on both channels, header timing and back-to-back writes.
    launch(2'b11, 0, 4);
    chk("hdr_state_busy", 32'(busy), 32'h3);
    chk("hdr_state_wr", 32'(wr), 32'h0);
    wait_drain(2'b11);
    chk("t1_c0_hdr", wlog[0][0], 32'hA000_0000);
    chk("t1_c0_w0", wlog[0][1], 32'h0);
    chk("t1_c0_w3", wlog[0][4], 32'h3);
    chk("t1_c1_hdr", wlog[1][0], 32'hA100_0000);
    chk("t1_c1_w2", wlog[1][3], 32'h2);
    chk("t1_hdr_latency", 32'(wcyc[0][0] - launch_cyc), 32'd1);
    chk("t1_burst_len", 32'(wcyc[0][4] - wcyc[0][0]), 32'd4);
    @(negedge clk);
    chk("t1_busy_wait", 32'(busy), 32'h3);

    // done and en together: IDLE after the done edge, next header two edges later.
    for (int c = 0; c < NCH; c++) begin
      push_pkt(c, 0, 4);
      wlog[c].delete();
      wcyc[c].delete();
    end
    en = 2'b11; mode = 2'd0; len = LW'(4); done = 2'b11;
    @(negedge clk);
    done = '0;
    jc = cyc;
    chk("t1b_idle_after_done", 32'(busy), 32'h0);
    @(negedge clk);
    en = '0;
    finish_pkt(2'b11);
    chk("t1b_restart_latency", 32'(wcyc[0][0] - jc), 32'd2);
    chk("t1b_c0_hdr", wlog[0][0], 32'hA000_0001);
    chk("t1b_c1_cnt", wlog[1][1], 32'h4);

    // Walking one across the word-width boundary.
    launch(2'b11, 2, 34);
    finish_pkt(2'b11);
    chk("t2_c0_hdr", wlog[0][0], 32'hA000_0002);
    chk("t2_c0_i0", wlog[0][1], 32'h1);
    chk("t2_c0_i31", wlog[0][32], 32'h8000_0000);
    chk("t2_c1_i32", wlog[1][33], 32'h1);
    chk("t2_c1_i33", wlog[1][34], 32'h2);

    // Almost-full on ch0 for five edges mid-packet; ch1 keeps streaming.
    launch(2'b11, 0, 8);
    repeat (3) @(negedge clk);
    afull = 2'b01;
    repeat (5) @(negedge clk);
    afull = '0;
    finish_pkt(2'b11);
    chk("t3_c0_span", 32'(wcyc[0][8] - wcyc[0][0]), 32'd13);
    chk("t3_c0_gap", 32'(wcyc[0][3] - wcyc[0][2]), 32'd6);
    chk("t3_c1_span", 32'(wcyc[1][8] - wcyc[1][0]), 32'd8);
    chk("t3_c0_w2", wlog[0][3], 32'd10);

    // en dropped after two payload words; packet completes, channel stays idle.
    @(negedge clk);
    push_pkt(0, 3, 8);
    wlog[0].delete();
    wcyc[0].delete();
    en = 2'b01; mode = 2'd3; len = LW'(8);
    t = 0;
    while (wlog[0].size() < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (wlog[0].size() < 3) fail("t4_start_timeout", "got too few words want 3");
    en = '0;
    finish_pkt(2'b01);
    repeat (4) @(negedge clk);
    chk("t4_stays_idle", 32'(busy), 32'h0);
    chk("t4_word_count", 32'(wlog[0].size()), 32'd9);
    chk("t4_alt_even", wlog[0][1], 32'hAAAA_AAAA);
    chk("t4_alt_odd", wlog[0][2], 32'h5555_5555);

    // Zero length behaves as one payload word.
    launch(2'b10, 0, 0);
    finish_pkt(2'b10);
    chk("t5_len0_count", 32'(wlog[1].size()), 32'd2);
    chk("t5_hdr", wlog[1][0], 32'hA100_0004);
    chk("t5_cnt", wlog[1][1], 32'd16);

    // Full coincident with the header write on ch1 only.
    launch(2'b10, 3, 4);
    @(negedge clk);
    chk("t6_err_before", 32'(err), 32'h0);
    full = 2'b10;
    @(negedge clk);
    chk("t6_err_set", 32'(err), 32'h2);
    full = '0;
    finish_pkt(2'b10);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 32'(err), 32'h2);

    // Reset mid-packet in LFSR mode, then restart from the seeds.
    launch(2'b11, 1, 6);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t7_rst_wr", 32'(wr), 32'h0);
    chk("t7_rst_dt0", dt[31:0], 32'h0);
    chk("t7_rst_dt1", dt[63:32], 32'h0);
    chk("t7_rst_err", 32'(err), 32'h0);
    chk("t7_rst_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    launch(2'b11, 1, 34);
    finish_pkt(2'b11);
    chk("t7_c0_hdr", wlog[0][0], 32'hA000_0000);
    chk("t7_c1_hdr", wlog[1][0], 32'hA100_0000);
    chk("t7_c0_seed", wlog[0][1], 32'h1);
    chk("t7_c1_seed", wlog[1][1], 32'h2);
    chk("t7_c0_i31", wlog[0][32], 32'h8000_0000);
    chk("t7_c0_i32", wlog[0][33], 32'h0040_0007);
    chk("t7_c1_i32", wlog[1][33], 32'h0080_000E);
    chk("t7_c1_i33", wlog[1][34], 32'h0100_001C);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
